// File: rtl/decode_stage.sv
// decode_stage
//
// Registered instruction-decode pipeline stage that sits between fetch and
// register-read/execute. Every accepted instruction is sliced into its
// cond/opcode/Rn/Rm/Rd/imm fields on capture. A sign-extended immediate and
// an illegal-opcode flag are computed at the same time, and the results are
// held in an output register. A second (skid) register catches the one
// instruction that can arrive while the downstream stalls. Because of it,
// in_ready comes straight from a flop and the stage still sustains one
// instruction per clock.
//
// Optional feature macro: DECODE_COND_EVAL_EN
//   When defined, this adds the flags input (NZCV) and the out_cond_pass
//   output. out_cond_pass evaluates the ARM condition code of the output
//   entry against the flags.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               discard every buffered instruction and any input
//                       arriving in the same cycle
//   in_valid/in_ready   upstream handshake; in_ready is registered
//   in_instr, in_pc     instruction word and its address
//   out_valid/out_ready downstream handshake
//   out_cond .. out_rd  decoded register/opcode fields
//   out_imm             raw immediate field
//   out_shift_type/amt  shift sub-fields of the immediate
//   out_imm_sext        immediate sign-extended to DATA_W
//   out_illegal         opcode is outside the implemented range
//   out_pc              address of the output entry
//   flags               (DECODE_COND_EVAL_EN only) current NZCV flags
//   out_cond_pass       (DECODE_COND_EVAL_EN only) condition satisfied
module decode_stage #(
    parameter int INSTR_W = 32,
    parameter int OPC_W   = 5,
    parameter int REG_W   = 4,
    parameter int IMM_W   = 11,
    parameter int DATA_W  = 32,
    parameter int PC_W    = 32,
    parameter int NUM_OPC = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
`ifdef DECODE_COND_EVAL_EN
    input  logic [3:0]         flags,
    output logic               out_cond_pass,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_cond,
    output logic [OPC_W-1:0]   out_opcode,
    output logic [REG_W-1:0]   out_rn,
    output logic [REG_W-1:0]   out_rm,
    output logic [REG_W-1:0]   out_rd,
    output logic [IMM_W-1:0]   out_imm,
    output logic [1:0]         out_shift_type,
    output logic [4:0]         out_shift_amt,
    output logic [DATA_W-1:0]  out_imm_sext,
    output logic               out_illegal,
    output logic [PC_W-1:0]    out_pc
);

    // One extra bit lets NUM_OPC equal 2**OPC_W (no illegal opcodes).
    localparam logic [OPC_W:0] NUM_OPC_L = (OPC_W + 1)'(NUM_OPC);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]        cond;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rm;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic [DATA_W-1:0] imm_sext;
        logic              illegal;
        logic [PC_W-1:0]   pc;
    } entry_t;

    // Fields are packed from the MSB down:
    // cond, opcode, Rn, Rm, Rd, then imm in the low bits.
    function automatic entry_t decode(input logic [INSTR_W-1:0] instr,
                                      input logic [PC_W-1:0]    pc);
        entry_t e;
        e.cond     = instr[INSTR_W-1 -: 4];
        e.opcode   = instr[INSTR_W-5 -: OPC_W];
        e.rn       = instr[INSTR_W-5-OPC_W -: REG_W];
        e.rm       = instr[INSTR_W-5-OPC_W-REG_W -: REG_W];
        e.rd       = instr[INSTR_W-5-OPC_W-2*REG_W -: REG_W];
        e.imm      = instr[IMM_W-1:0];
        e.imm_sext = {{(DATA_W-IMM_W){instr[IMM_W-1]}}, instr[IMM_W-1:0]};
        e.illegal  = ({1'b0, e.opcode} >= NUM_OPC_L);
        e.pc       = pc;
        return e;
    endfunction

    state_t state;
    state_t state_next;
    logic   in_ready_q;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_entry;
    logic   in_hs;
    logic   out_hs;
    logic   load_main_in;
    logic   load_skid_in;
    logic   load_main_skid;

    assign in_entry  = decode(in_instr, in_pc);
    assign in_ready  = in_ready_q;
    assign out_valid = (state != EMPTY);
    assign in_hs     = in_valid & in_ready_q;
    assign out_hs    = out_valid & out_ready;

    // State register. in_ready is precomputed from the next state, so it
    // leaves the stage as a plain flop output. It equals "skid not occupied".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != TWO);
        end
    end

    // Next-state and register-load selection. A word goes to the skid only
    // when the main register is full and is not being drained this cycle.
    // Flush overrides everything. An output handshake in the same cycle has
    // already been seen downstream, so dropping the entry is correct.
    always_comb begin
        state_next     = state;
        load_main_in   = 1'b0;
        load_skid_in   = 1'b0;
        load_main_skid = 1'b0;
        case (state)
            EMPTY: begin
                if (in_hs) begin
                    state_next   = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (in_hs && out_hs) begin
                    load_main_in = 1'b1;
                end else if (in_hs) begin
                    state_next   = TWO;
                    load_skid_in = 1'b1;
                end else if (out_hs) begin
                    state_next = EMPTY;
                end
            end
            TWO: begin
                if (out_hs) begin
                    state_next     = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_skid_in   = 1'b0;
            load_main_skid = 1'b0;
        end
    end

    // Main and skid data registers. Contents are only loaded, never cleared
    // on drain, so the outputs stay stable while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_entry;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid_in) begin
                skid_q <= in_entry;
            end
        end
    end

    assign out_cond       = main_q.cond;
    assign out_opcode     = main_q.opcode;
    assign out_rn         = main_q.rn;
    assign out_rm         = main_q.rm;
    assign out_rd         = main_q.rd;
    assign out_imm        = main_q.imm;
    assign out_shift_type = main_q.imm[IMM_W-1 -: 2];
    assign out_shift_amt  = main_q.imm[IMM_W-3 -: 5];
    assign out_imm_sext   = main_q.imm_sext;
    assign out_illegal    = main_q.illegal;
    assign out_pc         = main_q.pc;

`ifdef DECODE_COND_EVAL_EN
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    // ARM condition-code evaluation against the live flags.
    // This is deliberately combinational, so a flag update made in the same
    // cycle is seen.
    always_comb begin
        out_cond_pass = 1'b0;
        case (out_cond)
            4'h0: out_cond_pass = flag_z;
            4'h1: out_cond_pass = ~flag_z;
            4'h2: out_cond_pass = flag_c;
            4'h3: out_cond_pass = ~flag_c;
            4'h4: out_cond_pass = flag_n;
            4'h5: out_cond_pass = ~flag_n;
            4'h6: out_cond_pass = flag_v;
            4'h7: out_cond_pass = ~flag_v;
            4'h8: out_cond_pass = flag_c & ~flag_z;
            4'h9: out_cond_pass = ~flag_c | flag_z;
            4'hA: out_cond_pass = (flag_n == flag_v);
            4'hB: out_cond_pass = (flag_n != flag_v);
            4'hC: out_cond_pass = ~flag_z & (flag_n == flag_v);
            4'hD: out_cond_pass = flag_z | (flag_n != flag_v);
            4'hE: out_cond_pass = 1'b1;
            default: out_cond_pass = 1'b0;
        endcase
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//
// Directed testbench for decode_stage with the default parameters.
// It covers:
//   - reset state
//   - single-instruction decode
//   - back-pressure through the skid buffer
//   - a continuous stream
//   - flush in the ONE and TWO states
//   - the illegal-opcode boundaries
//   - the immediate sign-extension
//   - asynchronous reset in the middle of a transfer
//   - condition evaluation, when DECODE_COND_EVAL_EN is defined
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_cond;
    logic [4:0]  out_opcode;
    logic [3:0]  out_rn;
    logic [3:0]  out_rm;
    logic [3:0]  out_rd;
    logic [10:0] out_imm;
    logic [1:0]  out_shift_type;
    logic [4:0]  out_shift_amt;
    logic [31:0] out_imm_sext;
    logic        out_illegal;
    logic [31:0] out_pc;
`ifdef DECODE_COND_EVAL_EN
    logic [3:0]  flags;
    logic        out_cond_pass;
`endif

    int vectors;
    int miscompares;

    decode_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
`ifdef DECODE_COND_EVAL_EN
        .flags          (flags),
        .out_cond_pass  (out_cond_pass),
`endif
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_cond       (out_cond),
        .out_opcode     (out_opcode),
        .out_rn         (out_rn),
        .out_rm         (out_rm),
        .out_rd         (out_rd),
        .out_imm        (out_imm),
        .out_shift_type (out_shift_type),
        .out_shift_amt  (out_shift_amt),
        .out_imm_sext   (out_imm_sext),
        .out_illegal    (out_illegal),
        .out_pc         (out_pc)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic        valid,
                                 input logic [31:0] instr,
                                 input logic [31:0] pc,
                                 input logic        ready,
                                 input logic        flsh);
        in_valid  = valid;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = ready;
        flush     = flsh;
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string       tag,
                               input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clk         = 1'b0;
        rst_n       = 1'b0;
`ifdef DECODE_COND_EVAL_EN
        flags       = 4'h0;
`endif
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Reset state
        #12;
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready",  64'(in_ready),  64'd1);
        checkOutput("reset_out_imm",   64'(out_imm),   64'd0);
        checkOutput("reset_out_pc",    64'(out_pc),    64'd0);
        rst_n = 1'b1;
        tick();

        // Single instruction, one-cycle latency
        $display("[TB] single instruction decode");
        applyStimulus(1'b1, 32'hE091A7FF, 32'h100, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("single_valid",      64'(out_valid),      64'd1);
        checkOutput("single_cond",       64'(out_cond),       64'hE);
        checkOutput("single_opcode",     64'(out_opcode),     64'h01);
        checkOutput("single_rn",         64'(out_rn),         64'd2);
        checkOutput("single_rm",         64'(out_rm),         64'd3);
        checkOutput("single_rd",         64'(out_rd),         64'd4);
        checkOutput("single_imm",        64'(out_imm),        64'h7FF);
        checkOutput("single_shift_type", 64'(out_shift_type), 64'd3);
        checkOutput("single_shift_amt",  64'(out_shift_amt),  64'h1F);
        checkOutput("single_imm_sext",   64'(out_imm_sext),   64'hFFFFFFFF);
        checkOutput("single_illegal",    64'(out_illegal),    64'd0);
        checkOutput("single_pc",         64'(out_pc),         64'h100);
        tick();
        checkOutput("single_drained", 64'(out_valid), 64'd0);

        // Back-pressure: the third word must wait in the upstream
        $display("[TB] back-pressure");
        applyStimulus(1'b1, 32'h1, 32'h0, 1'b0, 1'b0);
        tick();
        checkOutput("bp_ready_after1", 64'(in_ready), 64'd1);
        applyStimulus(1'b1, 32'h2, 32'h4, 1'b0, 1'b0);
        tick();
        checkOutput("bp_ready_after2", 64'(in_ready),  64'd0);
        checkOutput("bp_head_imm",     64'(out_imm),   64'd1);
        applyStimulus(1'b1, 32'h3, 32'h8, 1'b0, 1'b0);
        tick();
        checkOutput("bp_hold_imm",   64'(out_imm),   64'd1);
        checkOutput("bp_hold_valid", 64'(out_valid), 64'd1);
        checkOutput("bp_hold_ready", 64'(in_ready),  64'd0);
        applyStimulus(1'b1, 32'h3, 32'h8, 1'b1, 1'b0);
        tick();
        checkOutput("bp_out2_imm",  64'(out_imm),  64'd2);
        checkOutput("bp_out2_pc",   64'(out_pc),   64'h4);
        checkOutput("bp_ready_back", 64'(in_ready), 64'd1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("bp_out3_imm",   64'(out_imm),   64'd3);
        checkOutput("bp_out3_valid", 64'(out_valid), 64'd1);
        tick();
        checkOutput("bp_empty", 64'(out_valid), 64'd0);

        // Continuous stream at full throughput
        $display("[TB] continuous stream");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 32'h10 + 32'(i), 32'h200 + 32'(4 * i), 1'b1, 1'b0);
            tick();
            checkOutput("stream_valid", 64'(out_valid), 64'd1);
            checkOutput("stream_imm",   64'(out_imm),   64'h10 + 64'(i));
            checkOutput("stream_pc",    64'(out_pc),    64'h200 + 64'(4 * i));
            checkOutput("stream_ready", 64'(in_ready),  64'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("stream_drained", 64'(out_valid), 64'd0);

        // Flush while two entries are held, with a concurrent input
        $display("[TB] flush");
        applyStimulus(1'b1, 32'h21, 32'h300, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h22, 32'h304, 1'b0, 1'b0);
        tick();
        checkOutput("flush_two_ready", 64'(in_ready), 64'd0);
        checkOutput("flush_two_imm",   64'(out_imm),  64'h21);
        applyStimulus(1'b1, 32'h23, 32'h308, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_valid", 64'(out_valid), 64'd0);
        checkOutput("flush_ready", 64'(in_ready),  64'd1);
        tick();
        checkOutput("flush_no_ghost", 64'(out_valid), 64'd0);
        applyStimulus(1'b1, 32'h24, 32'h30C, 1'b1, 1'b0);
        tick();
        checkOutput("flush_next_valid", 64'(out_valid), 64'd1);
        checkOutput("flush_next_imm",   64'(out_imm),   64'h24);
        applyStimulus(1'b1, 32'h25, 32'h310, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush_one_valid", 64'(out_valid), 64'd0);
        tick();
        checkOutput("flush_one_ghost", 64'(out_valid), 64'd0);

        // Opcode legality boundaries and immediate sign extension
        $display("[TB] illegal opcode");
        applyStimulus(1'b1, 32'h0F800400, 32'h400, 1'b1, 1'b0);
        tick();
        checkOutput("illegal_1f",      64'(out_illegal),    64'd1);
        checkOutput("opcode_1f",       64'(out_opcode),     64'h1F);
        checkOutput("sext_neg",        64'(out_imm_sext),   64'hFFFFFC00);
        checkOutput("shift_type_neg",  64'(out_shift_type), 64'd2);
        checkOutput("shift_amt_zero",  64'(out_shift_amt),  64'd0);
        applyStimulus(1'b1, 32'h0B8003FF, 32'h404, 1'b1, 1'b0);
        tick();
        checkOutput("illegal_17",      64'(out_illegal),    64'd0);
        checkOutput("opcode_17",       64'(out_opcode),     64'h17);
        checkOutput("sext_pos",        64'(out_imm_sext),   64'h3FF);
        checkOutput("shift_type_pos",  64'(out_shift_type), 64'd1);
        checkOutput("shift_amt_pos",   64'(out_shift_amt),  64'h1F);
        applyStimulus(1'b1, 32'h0C000000, 32'h408, 1'b1, 1'b0);
        tick();
        checkOutput("illegal_18",      64'(out_illegal),    64'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();

        // Asynchronous reset with both registers occupied
        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 32'h41, 32'h500, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h42, 32'h504, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checkOutput("rst_pre_ready", 64'(in_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_mid_ready", 64'(in_ready),  64'd1);
        checkOutput("rst_mid_imm",   64'(out_imm),   64'd0);
        rst_n = 1'b1;
        tick();
        checkOutput("rst_after_valid", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("rst_after_valid2", 64'(out_valid), 64'd0);

`ifdef DECODE_COND_EVAL_EN
        // Condition evaluation against NZCV
        $display("[TB] condition evaluation");
        applyStimulus(1'b1, 32'h00000000, 32'h600, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        flags = 4'b0100;
        #1;
        checkOutput("cond_eq_z1", 64'(out_cond_pass), 64'd1);
        flags = 4'b0000;
        #1;
        checkOutput("cond_eq_z0", 64'(out_cond_pass), 64'd0);
        applyStimulus(1'b1, 32'hC0000000, 32'h604, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        flags = 4'b1001;
        #1;
        checkOutput("cond_gt", 64'(out_cond_pass), 64'd1);
        applyStimulus(1'b1, 32'hF0000000, 32'h608, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        flags = 4'b1111;
        #1;
        checkOutput("cond_nv", 64'(out_cond_pass), 64'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
